// File: rtl/rgb_pwm_fader.sv
// Three-channel PWM colour generator for the SB_RGBA_DRV inputs, with a linear
// fade engine that walks the displayed duty toward a handshaken target colour.
module rgb_pwm_fader #(
    parameter int PRESCALE     = 48,
    parameter int FADE_PERIODS = 4
) (
    input  logic       hw_clk,
    input  logic       rst_n,
    input  logic       tgt_valid,
    output logic       tgt_ready,
    input  logic [7:0] tgt_red,
    input  logic [7:0] tgt_green,
    input  logic [7:0] tgt_blue,
    input  logic       fade_en,
    output logic       pwm_red,
    output logic       pwm_green,
    output logic       pwm_blue,
    output logic       busy,
    output logic       fade_done
);

    localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FCNT_W = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FADE_PERIODS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] APPLY = 2'd1;
    localparam logic [1:0] FADE  = 2'd2;

    logic [1:0]        state;
    logic [PRE_W-1:0]  pre_cnt;
    logic [7:0]        pwm_cnt;
    logic [FCNT_W-1:0] fcnt;
    logic [7:0]        cur_red, cur_green, cur_blue;
    logic [7:0]        goal_red, goal_green, goal_blue;
    logic [7:0]        nxt_red, nxt_green, nxt_blue;
    logic              tick, frame_end, accept, arrived;

    // One LSB toward the goal; never overshoots because equality holds.
    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] goal);
        if (cur < goal)
            return cur + 8'd1;
        else if (cur > goal)
            return cur - 8'd1;
        else
            return cur;
    endfunction

    assign tick      = (pre_cnt == PRE_LAST);
    assign frame_end = tick && (pwm_cnt == 8'd255);
    assign tgt_ready = (state == IDLE);
    assign busy      = !tgt_ready;
    assign accept    = tgt_valid && tgt_ready;

    assign nxt_red   = step_toward(cur_red, goal_red);
    assign nxt_green = step_toward(cur_green, goal_green);
    assign nxt_blue  = step_toward(cur_blue, goal_blue);
    assign arrived   = (nxt_red == goal_red) && (nxt_green == goal_green)
                    && (nxt_blue == goal_blue);

    always_ff @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            pwm_cnt <= 8'd0;
        end else if (tick) begin
            pre_cnt <= '0;
            pwm_cnt <= pwm_cnt + 8'd1;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // Displayed duty only moves on frame_end, so a frame is never cut mid-way.
    always_ff @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            fcnt       <= '0;
            fade_done  <= 1'b0;
            cur_red    <= 8'd0;
            cur_green  <= 8'd0;
            cur_blue   <= 8'd0;
            goal_red   <= 8'd0;
            goal_green <= 8'd0;
            goal_blue  <= 8'd0;
        end else begin
            fade_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        goal_red   <= tgt_red;
                        goal_green <= tgt_green;
                        goal_blue  <= tgt_blue;
                        fcnt       <= '0;
                        state      <= fade_en ? FADE : APPLY;
                    end
                end
                APPLY: begin
                    if (frame_end) begin
                        cur_red   <= goal_red;
                        cur_green <= goal_green;
                        cur_blue  <= goal_blue;
                        fade_done <= 1'b1;
                        state     <= IDLE;
                    end
                end
                FADE: begin
                    if (frame_end) begin
                        if (fcnt == FCNT_LAST) begin
                            fcnt      <= '0;
                            cur_red   <= nxt_red;
                            cur_green <= nxt_green;
                            cur_blue  <= nxt_blue;
                            if (arrived) begin
                                fade_done <= 1'b1;
                                state     <= IDLE;
                            end
                        end else begin
                            fcnt <= fcnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strict compare: duty 255 stays high 255 of 256 counts, duty 0 never fires.
    always_ff @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_red   <= 1'b0;
            pwm_green <= 1'b0;
            pwm_blue  <= 1'b0;
        end else begin
            pwm_red   <= (pwm_cnt < cur_red);
            pwm_green <= (pwm_cnt < cur_green);
            pwm_blue  <= (pwm_cnt < cur_blue);
        end
    end

endmodule
